// File: rtl/layer_6_relu_pool_if.sv
// layer_6_relu_pool_if: snoop strobes, buffer read port and pooled-output stream of layer 6.
// The master modport is the pooling block; the slave modport is the surrounding buffer/consumer.
interface layer_6_relu_pool_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic              conv_start;
    logic              conv_wr_en;
    logic              layer_6_relu_begin;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] pool_data;
    logic [3:0]        pool_index;
    logic              pool_valid;
    logic              pool_ready;
    logic              layer_6_busy;
    logic              layer_6_complete;

    modport master (
        input  conv_start, conv_wr_en, layer_6_relu_begin, rd_data, pool_ready,
        output rd_en, rd_addr, pool_data, pool_index, pool_valid, layer_6_busy, layer_6_complete
    );

    modport slave (
        output conv_start, conv_wr_en, layer_6_relu_begin, rd_data, pool_ready,
        input  rd_en, rd_addr, pool_data, pool_index, pool_valid, layer_6_busy, layer_6_complete
    );
endinterface

// File: rtl/layer_6_relu_pool.sv
// layer_6_relu_pool: ReLU + 2x2/stride-2 max pooling over the buffered layer-5 feature map.
// Snoops buffer writes so a row pair is only read once it has been fully written.
module layer_6_relu_pool #(
    parameter int MAP_W  = 8,
    parameter int MAP_H  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input logic                 clk,
    input logic                 rst_n,
    layer_6_relu_pool_if.master bus
);
    localparam int NPIX  = MAP_W * MAP_H;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int PC_W  = (MAP_W > 2) ? $clog2(MAP_W / 2) : 1;
    localparam int PR_W  = (MAP_H > 2) ? $clog2(MAP_H / 2) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, OUT, DONE} state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          snoop_q, snoop_d, cnt_now;
    logic [PR_W-1:0]           pr_q, pr_n, sel_pr;
    logic [PC_W-1:0]           pc_q, pc_n, sel_pc;
    logic [1:0]                rd_cnt_q;
    logic                      begin_q, rv_q, last_pc, last_win, go;
    logic signed [DATA_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_nx, base;
    logic [DATA_W-1:0]         pool_data_q;
    logic [3:0]                pool_index_q;

    // In OUT the threshold and base are evaluated for the next window so reads restart right after acceptance
    always_comb begin
        last_pc    = pc_q == PC_W'(MAP_W / 2 - 1);
        last_win   = last_pc && pr_q == PR_W'(MAP_H / 2 - 1);
        pc_n       = last_pc ? '0 : pc_q + 1'b1;
        pr_n       = last_pc ? pr_q + 1'b1 : pr_q;
        sel_pr     = (state_q == OUT) ? pr_n : pr_q;
        sel_pc     = (state_q == OUT) ? pc_n : pc_q;
        cnt_now    = snoop_q + CNT_W'(bus.conv_wr_en && snoop_q < CNT_W'(NPIX));
        go         = int'(cnt_now) >= (int'(sel_pr) + 1) * 2 * MAP_W;
        base       = ADDR_W'(int'(sel_pr) * 2 * MAP_W + int'(sel_pc) * 2);
        rd_addr_nx = rd_addr_q + ((rd_cnt_q == 2'd1) ? ADDR_W'(MAP_W - 1) : ADDR_W'(1));
        snoop_d    = (bus.conv_start && (state_q == IDLE || state_q == DONE)) ? '0 : cnt_now;
        acc_d      = (rv_q && $signed(bus.rd_data) > acc_q) ? $signed(bus.rd_data) : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            snoop_q      <= '0;
            pr_q         <= '0;
            pc_q         <= '0;
            rd_cnt_q     <= '0;
            begin_q      <= 1'b0;
            rv_q         <= 1'b0;
            acc_q        <= '0;
            rd_addr_q    <= '0;
            pool_data_q  <= '0;
            pool_index_q <= '0;
        end else begin
            snoop_q <= snoop_d;
            begin_q <= bus.layer_6_relu_begin;
            rv_q    <= state_q == READ;
            acc_q   <= acc_d;
            case (state_q)
                IDLE: if (bus.layer_6_relu_begin && !begin_q) begin
                    state_q <= WAIT;
                    pr_q    <= '0;
                    pc_q    <= '0;
                end
                WAIT: if (go) begin
                    state_q   <= READ;
                    rd_addr_q <= base;
                    rd_cnt_q  <= '0;
                    acc_q     <= '0;
                end
                READ: begin
                    rd_cnt_q <= rd_cnt_q + 2'd1;
                    if (rd_cnt_q == 2'd3) state_q <= DRAIN;
                    else rd_addr_q <= rd_addr_nx;
                end
                DRAIN: begin
                    state_q      <= OUT;
                    pool_data_q  <= acc_d;
                    pool_index_q <= 4'(int'(pr_q) * (MAP_W / 2) + int'(pc_q));
                end
                OUT: if (bus.pool_ready) begin
                    pc_q <= pc_n;
                    pr_q <= pr_n;
                    if (last_win) state_q <= DONE;
                    else if (go) begin
                        state_q   <= READ;
                        rd_addr_q <= base;
                        rd_cnt_q  <= '0;
                        acc_q     <= '0;
                    end else state_q <= WAIT;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_en            = state_q == READ;
    assign bus.rd_addr          = rd_addr_q;
    assign bus.pool_data        = pool_data_q;
    assign bus.pool_index       = pool_index_q;
    assign bus.pool_valid       = state_q == OUT;
    assign bus.layer_6_busy     = state_q != IDLE;
    assign bus.layer_6_complete = state_q == DONE;
endmodule

// File: tb/tb_layer_6_relu_pool.sv
// tb_layer_6_relu_pool: directed bench with a buffer model and an output recorder.
`timescale 1ns/1ps
module tb_layer_6_relu_pool;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_6_relu_pool_if bus ();
    layer_6_relu_pool dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [64];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[5:0]];

    int checks = 0, errors = 0;
    int cyc = 0, wr_count = 0, ncomp = 0, viol = 0, comp_cyc = 0;
    int q_idx[$], q_dat[$], q_cyc[$], rd_start[$];
    logic rd_en_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Records accepted windows, completion pulses, read starts and reads ahead of the written data
    always @(negedge clk) if (rst_n) begin
        if (bus.pool_valid && bus.pool_ready) begin
            q_idx.push_back(int'(bus.pool_index));
            q_dat.push_back(int'(bus.pool_data));
            q_cyc.push_back(cyc);
        end
        if (bus.layer_6_complete) begin
            ncomp++;
            comp_cyc = cyc;
        end
        if (bus.rd_en && int'(bus.rd_addr) >= wr_count) viol++;
        if (bus.rd_en && !rd_en_prev) rd_start.push_back(cyc);
        rd_en_prev = bus.rd_en;
    end

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] map_val(int kind, int a);
        logic [7:0] v;
        v = 8'(a);
        if (kind == 1) begin
            v = 8'h80 + 8'(a);
            if (a == 0) v = 8'hFB;
            if (a == 1) v = 8'h03;
            if (a == 8) v = 8'h80;
            if (a == 9) v = 8'h7F;
            if (a == 2 || a == 3 || a == 10 || a == 11) v = 8'hFF;
        end
        return v;
    endfunction

    function automatic int exp_val(int kind, int k);
        return (kind == 0) ? 16 * (k / 4) + 2 * (k % 4) + 9 : ((k == 0) ? 127 : 0);
    endfunction

    task automatic conv_start_pulse;
        bus.conv_start = 1'b1;
        tick();
        bus.conv_start = 1'b0;
        wr_count = 0;
    endtask

    task automatic write_one(logic [7:0] v, int gap);
        mem[wr_count] = v;
        bus.conv_wr_en = 1'b1;
        wr_count++;
        tick();
        bus.conv_wr_en = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    task automatic start_run(int kind);
        conv_start_pulse();
        for (int i = 0; i < 64; i++) write_one(map_val(kind, i), 0);
        bus.layer_6_relu_begin = 1'b1;
    endtask

    task automatic wait_done(string tag, int nc0);
        for (int i = 0; i < 3000 && ncomp == nc0; i++) tick();
        chk({tag, "_finished"}, int'(ncomp > nc0), 1);
    endtask

    task automatic check_run(string tag, int kind, int qb, int rb, int nc0);
        chk({tag, "_count"}, q_idx.size() - qb, 16);
        for (int k = 0; k < 16 && qb + k < q_idx.size(); k++) begin
            chk($sformatf("%s_idx%0d", tag, k), q_idx[qb + k], k);
            chk($sformatf("%s_dat%0d", tag, k), q_dat[qb + k], exp_val(kind, k));
        end
        chk({tag, "_complete_pulses"}, ncomp - nc0, 1);
        if (q_cyc.size() >= qb + 16) chk({tag, "_complete_timing"}, comp_cyc, q_cyc[qb + 15] + 1);
        if (q_cyc.size() > qb && rd_start.size() > rb + 1)
            chk({tag, "_w1_read_start"}, rd_start[rb + 1], q_cyc[qb] + 1);
        chk({tag, "_busy_after"}, int'(bus.layer_6_busy), 0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
        chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
        chk({tag, "_valid"}, int'(bus.pool_valid), 0);
        chk({tag, "_data"}, int'(bus.pool_data), 0);
        chk({tag, "_index"}, int'(bus.pool_index), 0);
        chk({tag, "_busy"}, int'(bus.layer_6_busy), 0);
        chk({tag, "_complete"}, int'(bus.layer_6_complete), 0);
    endtask

    initial begin
        int qb, rb, nc0, v0, bad, d, ix;
        bus.conv_start = 1'b0;
        bus.conv_wr_en = 1'b0;
        bus.layer_6_relu_begin = 1'b0;
        bus.pool_ready = 1'b1;
        tick(2);
        check_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Full ramp map, ready tied high
        qb = q_idx.size(); rb = rd_start.size(); nc0 = ncomp;
        start_run(0);
        tick();
        chk("ramp_busy", int'(bus.layer_6_busy), 1);
        wait_done("ramp", nc0);
        tick(2);
        check_run("ramp", 0, qb, rb, nc0);
        if (q_cyc.size() > qb + 1) chk("ramp_period", q_cyc[qb + 1] - q_cyc[qb], 6);
        bus.layer_6_relu_begin = 1'b0;
        tick(2);

        // Negative map with two hand-built windows
        qb = q_idx.size(); rb = rd_start.size(); nc0 = ncomp;
        start_run(1);
        wait_done("neg", nc0);
        tick(2);
        check_run("neg", 1, qb, rb, nc0);
        bus.layer_6_relu_begin = 1'b0;
        tick(2);

        // Trickled writes, one every 4 cycles, begin after 16
        qb = q_idx.size(); rb = rd_start.size(); nc0 = ncomp; v0 = viol;
        conv_start_pulse();
        fork
            for (int i = 0; i < 64; i++) write_one(map_val(0, i), 3);
        join_none
        for (int i = 0; i < 2000 && wr_count < 16; i++) tick();
        bus.layer_6_relu_begin = 1'b1;
        wait_done("trickle", nc0);
        tick(4);
        check_run("trickle", 0, qb, rb, nc0);
        chk("trickle_early_reads", viol - v0, 0);
        bus.layer_6_relu_begin = 1'b0;
        tick(2);

        // Back-pressure on window 5
        qb = q_idx.size(); rb = rd_start.size(); nc0 = ncomp;
        start_run(0);
        for (int i = 0; i < 500 && q_idx.size() < qb + 5; i++) tick();
        tick();
        bus.pool_ready = 1'b0;
        for (int i = 0; i < 50 && !bus.pool_valid; i++) tick();
        d = int'(bus.pool_data);
        ix = int'(bus.pool_index);
        chk("stall_index", ix, 5);
        chk("stall_data", d, 27);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(bus.pool_valid && int'(bus.pool_data) == d && int'(bus.pool_index) == ix && !bus.rd_en)) bad++;
        end
        chk("stall_hold", bad, 0);
        bus.pool_ready = 1'b1;
        wait_done("stall", nc0);
        tick(2);
        check_run("stall", 0, qb, rb, nc0);
        if (q_cyc.size() > qb + 5 && rd_start.size() > rb + 6)
            chk("stall_w6_read_start", rd_start[rb + 6], q_cyc[qb + 5] + 1);
        bus.layer_6_relu_begin = 1'b0;
        tick(2);

        // Reset during the reads of window 7, then a clean rerun
        qb = q_idx.size(); nc0 = ncomp;
        start_run(0);
        for (int i = 0; i < 500 && !(q_idx.size() >= qb + 7 && bus.rd_en); i++) tick();
        chk("abort_in_read", int'(bus.rd_en), 1);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        tick(3);
        bus.layer_6_relu_begin = 1'b0;
        rst_n = 1'b1;
        tick(3);
        chk("abort_no_complete", ncomp - nc0, 0);
        qb = q_idx.size(); rb = rd_start.size(); nc0 = ncomp;
        start_run(0);
        wait_done("rerun", nc0);
        tick(2);
        check_run("rerun", 0, qb, rb, nc0);
        bus.layer_6_relu_begin = 1'b0;
        tick(2);

        // Begin held high, with an extra rising edge while window 3 is offered
        qb = q_idx.size(); rb = rd_start.size(); nc0 = ncomp;
        start_run(0);
        for (int i = 0; i < 500 && !(q_idx.size() >= qb + 3 && bus.rd_en); i++) tick();
        bus.layer_6_relu_begin = 1'b0;
        for (int i = 0; i < 50 && !bus.pool_valid; i++) tick();
        bus.layer_6_relu_begin = 1'b1;
        wait_done("rebegin", nc0);
        tick(40);
        check_run("rebegin", 0, qb, rb, nc0);
        bus.layer_6_relu_begin = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
